fc_argmax: RTL and testbench
============================

Name: fc_argmax

Overview:
- Downstream stage of the convolution engine. Consumes the 26x26 = 676 conv activations as a stream and runs the 676x10 fully-connected layer with 10 parallel MAC lanes.
- Adds the per-class bias, then selects the winning class by sequential argmax.
- Drives the 8-bit class result that appears as the accelerator's o_res.
- Weights come from an external synchronous ROM (one row of 10 weights per activation index).

Parameters:
- N_ACT, 676, activations per inference (conv output size).
- NUM_CLS, 10, number of output classes / MAC lanes.
- ACT_W, 8, activation width, signed two's complement.
- W_W, 8, FC weight width, signed.
- BIAS_W, 16, FC bias width, signed.
- ACC_W, 32, accumulator width, signed; must be >= ACT_W+W_W+clog2(N_ACT)+1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  begin inference; sampled only in IDLE.
- i_act_valid  in  1  activation valid.
- i_act  in  ACT_W  activation data, signed.
- o_act_ready  out  1  block accepts activation.
- o_w_addr  out  clog2(N_ACT)  weight-ROM row address.
- i_w_data  in  NUM_CLS*W_W  ROM row, valid 1 cycle after address; class 0 in LSBs.
- i_fc_bias  in  NUM_CLS*BIAS_W  biases, class 0 in LSBs; stable from start to done.
- o_res  out  8  winning class index.
- o_done  out  1  one-cycle pulse, o_res valid.

Behaviour:
- Interface: one clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset: state IDLE, all accumulators 0, act counter 0, o_act_ready 0, o_w_addr 0, o_res 0, o_done 0.
- States: IDLE -> ACCUM -> DRAIN -> BIAS -> ARGMAX -> DONE -> IDLE.
- IDLE: o_act_ready=0. i_start=1 clears accumulators and counter, then goes to ACCUM.
- ACCUM, acceptance:
  - o_act_ready=1; accept on i_act_valid & o_act_ready.
  - On accept: o_w_addr = current counter value (combinational from counter). Activation is registered into a 1-deep pipe with a valid flag. Counter increments.
- ACCUM, accumulation:
  - In the cycle after an accept, each lane j adds sext(act*w_j) to acc_j, where w_j is slice j of i_w_data.
  - Bubbles (i_act_valid=0) add nothing; the pipe valid flag gates accumulation.
- End of ACCUM: the accept of activation N_ACT-1 moves the state to DRAIN. o_act_ready drops in the same edge, so at most N_ACT accepts occur.
- DRAIN: the final product accumulates, then go to BIAS.
- BIAS: acc_j += sext(bias_j) for all lanes in one cycle, then go to ARGMAX with best=acc_0, best_idx=0, idx=1.
- ARGMAX:
  - One class per cycle, idx 1..NUM_CLS-1.
  - Replace best only if acc_idx > best (strict, signed). Ties therefore keep the lowest index.
  - After idx=NUM_CLS-1, register o_res=best_idx (zero-extended) and go to DONE.
- DONE: o_done=1 for exactly one cycle; return to IDLE. o_res holds until the next DONE or reset.
- Latency: o_done is high in the cycle beginning 12 edges after the edge that accepted the last activation (DRAIN 1, BIAS 1, ARGMAX 9, DONE register 1).
- Arithmetic:
  - Products are full signed precision.
  - Accumulation wraps modulo 2^ACC_W. With default widths no overflow is possible.
- i_start outside IDLE is ignored.
- i_act_valid outside ACCUM is ignored.
- i_rst mid-operation aborts immediately to reset values. No o_done is produced for the aborted inference.

Decomposition:
- Shared package cnn_pkg:
  - Constants N_ACT, NUM_CLS, ACT_W, W_W, BIAS_W, ACC_W.
  - State enum fc_state_t (IDLE, ACCUM, DRAIN, BIAS, ARGMAX, DONE).
- Sub-module fc_mac_lane:
  - One signed multiply-accumulate lane with clear, accumulate-enable and bias-add-enable inputs.
  - Instantiated NUM_CLS times via generate.
- FSM, counter, activation pipe and argmax stay in fc_argmax.

Test Plan:
- All activations = 1, weights w_j = j-5 for every row, biases 0, i_act_valid held high -> acc_j = 676*(j-5); o_res=9. o_done exactly 12 cycles after the last accept; exactly 676 accepts.
- All activations = -1 (0xFF), w_j = j, biases 0 -> acc_j = -676*j; o_res=0 (signed compare).
- Weights all 0, bias_3=100, other biases -1 -> o_res=3. Then weights all 0, all biases 7 -> o_res=0 (tie goes to lowest index).
- Repeat the first case with i_act_valid toggling every other cycle -> o_res=9. o_w_addr increments only on accepts; o_act_ready deasserts after the 676th accept.
- Assert i_rst after 300 accepts -> next cycle o_act_ready=0, o_res=0, no o_done pulse. A fresh i_start plus a full first-case stream gives o_res=9.
- Pulse i_start during ACCUM and during ARGMAX -> ignored; result and timing identical to the undisturbed run.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants, FSM state type and sign-extension helpers for the CNN
// accelerator back end (fully-connected layer + argmax).
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int N_ACT   = 676;   // activations per inference (26x26 conv map)
    localparam int NUM_CLS = 10;    // output classes == parallel MAC lanes
    localparam int ACT_W   = 8;     // signed activation width
    localparam int W_W     = 8;     // signed FC weight width
    localparam int BIAS_W  = 16;    // signed FC bias width
    localparam int ACC_W   = 32;    // signed accumulator width

    localparam int ADDR_W  = $clog2(N_ACT);
    localparam int IDX_W   = $clog2(NUM_CLS);
    localparam int PROD_W  = ACT_W + W_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        DRAIN  = 3'd2,
        BIAS   = 3'd3,
        ARGMAX = 3'd4,
        DONE   = 3'd5
    } fc_state_t;

    // Full-precision signed product, sign-extended to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_prod(
        input logic signed [ACT_W-1:0] a,
        input logic signed [W_W-1:0]   w
    );
        logic signed [PROD_W-1:0] p;
        p = a * w;
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Bias sign-extended to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_bias(
        input logic signed [BIAS_W-1:0] b
    );
        return {{(ACC_W-BIAS_W){b[BIAS_W-1]}}, b};
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// -----------------------------------------------------------------------------
// fc_mac_lane
// One signed multiply-accumulate lane of the fully-connected layer.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          zero the accumulator (start of inference)
//   i_acc_en       add sext(i_act * i_w)
//   i_bias_en      add sext(i_bias)
//   i_act, i_w     activation and this lane's weight (signed)
//   i_bias         this lane's bias (signed)
//   o_acc          accumulator value (wraps modulo 2^ACC_W)
// -----------------------------------------------------------------------------
module fc_mac_lane
    import cnn_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_acc_en,
    input  logic                     i_bias_en,
    input  logic signed [ACT_W-1:0]  i_act,
    input  logic signed [W_W-1:0]    i_w,
    input  logic signed [BIAS_W-1:0] i_bias,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [ACC_W-1:0] acc_r;

    // Accumulator: clear, multiply-accumulate or bias add (mutually exclusive by FSM).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_r <= '0;
        end else if (i_clr) begin
            acc_r <= '0;
        end else if (i_acc_en) begin
            acc_r <= acc_r + sext_prod(i_act, i_w);
        end else if (i_bias_en) begin
            acc_r <= acc_r + sext_bias(i_bias);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign o_acc = acc_r;

endmodule

// File: rtl/fc_argmax.sv
// -----------------------------------------------------------------------------
// fc_argmax
// Streams the 676 conv activations through a 676x10 fully-connected layer
// (10 parallel MAC lanes), adds per-class biases and picks the winning class
// by a sequential signed argmax (ties keep the lowest index).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        begin inference (only honoured in IDLE)
//   i_act_valid    activation valid; i_act signed activation
//   o_act_ready    high while activations are accepted
//   o_w_addr       weight-ROM row address (= activation index of an accept)
//   i_w_data       ROM row, one cycle after o_w_addr, class 0 in LSBs
//   i_fc_bias      per-class biases, class 0 in LSBs, stable start..done
//   o_res          winning class index, held until next result or reset
//   o_done         one-cycle pulse when o_res is updated
// -----------------------------------------------------------------------------
module fc_argmax
    import cnn_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_act_valid,
    input  logic [ACT_W-1:0]            i_act,
    output logic                        o_act_ready,
    output logic [ADDR_W-1:0]           o_w_addr,
    input  logic [NUM_CLS*W_W-1:0]      i_w_data,
    input  logic [NUM_CLS*BIAS_W-1:0]   i_fc_bias,
    output logic [7:0]                  o_res,
    output logic                        o_done
);

    fc_state_t               state_r;
    logic [ADDR_W-1:0]       cnt_r;
    logic                    ready_r;
    logic signed [ACT_W-1:0] act_r;
    logic                    pipe_vld_r;
    logic [IDX_W-1:0]        idx_r;
    logic signed [ACC_W-1:0] best_r;
    logic [IDX_W-1:0]        best_idx_r;
    logic [7:0]              res_r;
    logic                    done_r;

    logic                    accept_s;
    logic                    last_s;
    logic                    clr_s;
    logic                    bias_en_s;
    logic signed [ACC_W-1:0] acc_s [NUM_CLS];
    logic signed [ACC_W-1:0] cand_s;
    logic signed [ACC_W-1:0] ref_s;
    logic                    win_s;
    logic signed [ACC_W-1:0] new_best_s;
    logic [IDX_W-1:0]        new_idx_s;

    assign accept_s  = i_act_valid & ready_r;
    assign last_s    = (cnt_r == ADDR_W'(N_ACT - 1));
    assign clr_s     = (state_r == IDLE) & i_start;
    assign bias_en_s = (state_r == BIAS);

    // MAC lanes; the pipe valid flag gates accumulation so bubbles add nothing.
    for (genvar j = 0; j < NUM_CLS; j++) begin : g_lane
        fc_mac_lane u_lane (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_clr     (clr_s),
            .i_acc_en  (pipe_vld_r),
            .i_bias_en (bias_en_s),
            .i_act     (act_r),
            .i_w       (i_w_data[j*W_W +: W_W]),
            .i_bias    (i_fc_bias[j*BIAS_W +: BIAS_W]),
            .o_acc     (acc_s[j])
        );
    end

    // Argmax compare step. Lane 0 only receives its bias on the same edge that
    // enters ARGMAX, so on the first step (idx 1) the reference is read from
    // lane 0 directly instead of from best_r.
    always_comb begin
        cand_s = acc_s[idx_r];
        if (idx_r == IDX_W'(1)) begin
            ref_s = acc_s[0];
        end else begin
            ref_s = best_r;
        end
        win_s = (cand_s > ref_s);
        if (win_s) begin
            new_best_s = cand_s;
            new_idx_s  = idx_r;
        end else begin
            new_best_s = ref_s;
            new_idx_s  = best_idx_r;
        end
    end

    // Main FSM, activation counter and ready flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        cnt_r   <= '0;
                        ready_r <= 1'b1;
                        state_r <= ACCUM;
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + ADDR_W'(1);
                        if (last_s) begin
                            // ready drops on the same edge: no accept past N_ACT
                            ready_r <= 1'b0;
                            state_r <= DRAIN;
                        end else begin
                            ready_r <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                DRAIN:   state_r <= BIAS;
                BIAS:    state_r <= ARGMAX;
                ARGMAX: begin
                    if (idx_r == IDX_W'(NUM_CLS - 1)) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= ARGMAX;
                    end
                end
                DONE:    state_r <= IDLE;
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // One-deep activation pipe aligning data with the registered ROM row.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            act_r      <= '0;
            pipe_vld_r <= 1'b0;
        end else begin
            pipe_vld_r <= accept_s;
            if (accept_s) begin
                act_r <= i_act;
            end else begin
                act_r <= act_r;
            end
        end
    end

    // Sequential argmax registers and the held class result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_r      <= '0;
            best_r     <= '0;
            best_idx_r <= '0;
            res_r      <= 8'd0;
        end else begin
            case (state_r)
                BIAS: begin
                    idx_r      <= IDX_W'(1);
                    best_idx_r <= '0;
                end
                ARGMAX: begin
                    idx_r      <= idx_r + IDX_W'(1);
                    best_r     <= new_best_s;
                    best_idx_r <= new_idx_s;
                    if (idx_r == IDX_W'(NUM_CLS - 1)) begin
                        res_r <= {{(8-IDX_W){1'b0}}, new_idx_s};
                    end else begin
                        res_r <= res_r;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Registered one-cycle completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == DONE);
        end
    end

    assign o_act_ready = ready_r;
    assign o_w_addr    = cnt_r;
    assign o_res       = res_r;
    assign o_done      = done_r;

endmodule

// File: tb/tb_fc_argmax.sv
module tb_fc_argmax
    import cnn_pkg::*;
;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic                      act_valid;
    logic [ACT_W-1:0]          act;
    logic                      act_ready;
    logic [ADDR_W-1:0]         w_addr;
    logic [NUM_CLS*W_W-1:0]    w_data;
    logic [NUM_CLS*BIAS_W-1:0] fc_bias;
    logic [7:0]                res;
    logic                      done;

    int  n_checks = 0;
    int  n_fail   = 0;

    int  acts     [N_ACT];
    byte wmem     [N_ACT][NUM_CLS];
    int  bias_arr [NUM_CLS];

    fc_argmax dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_act_valid (act_valid),
        .i_act       (act),
        .o_act_ready (act_ready),
        .o_w_addr    (w_addr),
        .i_w_data    (w_data),
        .i_fc_bias   (fc_bias),
        .o_res       (res),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous weight ROM model
    always @(posedge clk) begin
        if (w_addr < ADDR_W'(N_ACT)) begin
            for (int j = 0; j < NUM_CLS; j++) w_data[j*W_W +: W_W] <= wmem[w_addr][j];
        end else begin
            w_data <= '0;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference: dot products + bias, then first strict maximum
    function automatic int model_argmax();
        longint acc [NUM_CLS];
        int best;
        for (int j = 0; j < NUM_CLS; j++) acc[j] = bias_arr[j];
        for (int k = 0; k < N_ACT; k++)
            for (int j = 0; j < NUM_CLS; j++)
                acc[j] += longint'(acts[k]) * longint'(wmem[k][j]);
        best = 0;
        for (int j = 1; j < NUM_CLS; j++)
            if (int'(acc[j]) > int'(acc[best])) best = j;
        return best;
    endfunction

    task automatic set_case(input int kind);
        for (int k = 0; k < N_ACT; k++) begin
            case (kind)
                0: acts[k] = 1;
                1: acts[k] = -1;
                default: acts[k] = int'($urandom_range(0, 255)) - 128;
            endcase
            for (int j = 0; j < NUM_CLS; j++) begin
                case (kind)
                    0: wmem[k][j] = byte'(j - 5);
                    1: wmem[k][j] = byte'(j);
                    2, 3: wmem[k][j] = 8'sd0;
                    default: wmem[k][j] = byte'($urandom_range(0, 255));
                endcase
            end
        end
        for (int j = 0; j < NUM_CLS; j++) begin
            case (kind)
                2: bias_arr[j] = (j == 3) ? 100 : -1;
                3: bias_arr[j] = 7;
                4: bias_arr[j] = int'($urandom_range(0, 65535)) - 32768;
                default: bias_arr[j] = 0;
            endcase
            fc_bias[j*BIAS_W +: BIAS_W] = 16'(bias_arr[j]);
        end
    endtask

    // vmode: 0 valid always, 1 valid every other cycle, 2 random valid
    task automatic run_inf(input int vmode, input int abort_at, input bit disturb);
        int  n_acc;
        int  guard;
        int  waits;
        int  dones;
        int  exp;
        bit  v;
        exp = model_argmax();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_acc = 0;
        guard = 0;
        while (n_acc < N_ACT && guard < 5000) begin
            check_eq("w_addr", w_addr, n_acc);
            check_eq("act_ready_accum", act_ready, 1);
            if (vmode == 0) v = 1'b1;
            else if (vmode == 1) v = (guard % 2 == 0);
            else v = ($urandom_range(0, 1) == 1);
            if (abort_at >= 0 && n_acc == abort_at) begin
                rst = 1'b1;
                act_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_eq("abort_ready", act_ready, 0);
                check_eq("abort_res", res, 0);
                check_eq("abort_w_addr", w_addr, 0);
                rst = 1'b0;
                dones = 0;
                act_valid = 1'b1;
                repeat (30) begin
                    @(negedge clk);
                    if (done) dones++;
                    if (act_ready) dones += 100;
                end
                act_valid = 1'b0;
                check_eq("abort_no_done", dones, 0);
                return;
            end
            act_valid = v;
            act = 8'(acts[n_acc]);
            start = disturb && (n_acc == 100);
            @(posedge clk);
            if (v) n_acc++;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check_eq("accept_count", n_acc, N_ACT);
        check_eq("act_ready_after", act_ready, 0);
        check_eq("w_addr_after", w_addr, N_ACT);
        // extra valid data must be ignored now
        act_valid = 1'b1;
        act = 8'($urandom_range(0, 255));
        waits = 0;
        while (!done && waits < 40) begin
            start = disturb && (waits == 5);
            @(posedge clk);
            waits++;
            @(negedge clk);
        end
        start = 1'b0;
        act_valid = 1'b0;
        check_eq("latency", waits, 12);
        check_eq("res", res, exp);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("res_hold", res, exp);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        act_valid = 1'b0;
        act = '0;
        fc_bias = '0;
        set_case(0);
        repeat (3) @(negedge clk);
        check_eq("rst_ready", act_ready, 0);
        check_eq("rst_w_addr", w_addr, 0);
        check_eq("rst_res", res, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b0;

        set_case(0); check_eq("model_case0", model_argmax(), 9);
        run_inf(0, -1, 1'b0);
        set_case(1); check_eq("model_case1", model_argmax(), 0);
        run_inf(0, -1, 1'b0);
        set_case(2); check_eq("model_case2", model_argmax(), 3);
        run_inf(0, -1, 1'b0);
        set_case(3); check_eq("model_case3", model_argmax(), 0);
        run_inf(0, -1, 1'b0);
        set_case(0);
        run_inf(1, -1, 1'b0);
        run_inf(0, 300, 1'b0);
        run_inf(0, -1, 1'b0);
        run_inf(0, -1, 1'b1);
        for (int r = 0; r < 3; r++) begin
            set_case(4);
            run_inf(2, -1, (r == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
